// File: rtl/countdown_timer.sv
// Loadable down-counting timer: decrements once per prescaler tick, pulses done on expiry.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN adds reload_en for periodic restart from the last load value.
module countdown_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         start,
    input  logic [W-1:0] load_val,
    input  logic         pause,
    input  logic         abort,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    input  logic         reload_en,
`endif
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        EXPIRE = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [W-1:0]   reload_q, reload_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = load_val;
`endif
                    // A zero-length timer still produces its done pulse.
                    state_d = (load_val != '0) ? RUN : EXPIRE;
                end
            end
            RUN: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (pause) begin
                    state_d = HOLD;
                end else if (tick) begin
                    // RUN is never entered with count==0, so no underflow path exists.
                    if (count_q == W'(1)) begin
                        count_d = '0;
                        state_d = EXPIRE;
                    end else begin
                        count_d = count_q - W'(1);
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            EXPIRE: begin
                state_d = IDLE;
                count_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (!abort && reload_en && (reload_q != '0)) begin
                    count_d = reload_q;
                    state_d = RUN;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    assign count = count_q;
    assign busy  = (state_q == RUN) || (state_q == HOLD);
    assign done  = (state_q == EXPIRE);

endmodule
